// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART RX packet framer.
// Imported by the top and the gap timer.
package uart_rx_pkt_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         MAX_LEN_DEF     = 16;
  localparam int         ADDR_W_DEF      = 4;
  localparam int         TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/uart_rx_pkt_ctrl_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and
// flags the TIMEOUT_CYC-th consecutive cycle without a clear.
module rx_gap_timer
  import uart_rx_pkt_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr || !en)
      cnt <= '0;
    else if (cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  // A byte arriving on the final cycle wins over the timeout.
  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART RX bytes into SYNC|LEN|payload|CSUM packets and holds
// a good payload in a local buffer until the consumer acks it.
module uart_rx_pkt_ctrl
  import uart_rx_pkt_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         MAX_LEN     = MAX_LEN_DEF,
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              rx_en,
  output logic              pkt_valid,
  input  logic              pkt_ack,
  output logic [ADDR_W:0]   pkt_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              err_csum,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_ovr
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [7:0]        csum, csum_n;
  logic              valid_n, rx_en_n;
  logic [ADDR_W:0]   pkt_len_n;
  logic              e_csum_n, e_len_n, e_to_n, e_ovr_n;
  logic              buf_we, tmr_en, expire;
  logic [7:0]        mem [MAX_LEN];

  rx_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (rx_done),
    .en     (tmr_en),
    .expire (expire)
  );

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    idx_n     = idx;
    csum_n    = csum;
    valid_n   = pkt_valid;
    pkt_len_n = pkt_len;
    rx_en_n   = rx_en;
    e_csum_n  = 1'b0;
    e_len_n   = 1'b0;
    e_to_n    = 1'b0;
    e_ovr_n   = 1'b0;
    buf_we    = 1'b0;
    tmr_en    = (state == ST_LEN) || (state == ST_PAYLOAD) ||
                (state == ST_CSUM);
    unique case (state)
      ST_IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE)
          state_n = ST_LEN;
      end
      ST_LEN: begin
        if (rx_done) begin
          csum_n = rx_data;
          if (rx_data > MAX_LEN_B) begin
            e_len_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            len_n   = rx_data[ADDR_W:0];
            idx_n   = '0;
            state_n = (rx_data == 8'h00) ? ST_CSUM : ST_PAYLOAD;
          end
        end else if (expire) begin
          e_to_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          buf_we = 1'b1;
          csum_n = csum ^ rx_data;
          idx_n  = idx + 1'b1;
          if ({1'b0, idx} == len_q - 1'b1)
            state_n = ST_CSUM;
        end else if (expire) begin
          e_to_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_CSUM: begin
        if (rx_done) begin
          if (rx_data == csum) begin
            state_n   = ST_HOLD;
            valid_n   = 1'b1;
            pkt_len_n = len_q;
            rx_en_n   = 1'b0;
          end else begin
            e_csum_n = 1'b1;
            state_n  = ST_IDLE;
          end
        end else if (expire) begin
          e_to_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_HOLD: begin
        e_ovr_n = rx_done;
        if (pkt_ack) begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
          rx_en_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      idx         <= '0;
      csum        <= '0;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      rx_en       <= 1'b1;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      idx         <= idx_n;
      csum        <= csum_n;
      pkt_valid   <= valid_n;
      pkt_len     <= pkt_len_n;
      rx_en       <= rx_en_n;
      err_csum    <= e_csum_n;
      err_len     <= e_len_n;
      err_timeout <= e_to_n;
      err_ovr     <= e_ovr_n;
    end
  end

  // Payload storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (buf_we)
      mem[idx] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= 8'h00;
    else if ({1'b0, rd_addr} < pkt_len)
      rd_data <= mem[rd_addr];
    else
      rd_data <= 8'h00;
  end

endmodule
